// File: rtl/branch_ctrl.sv
// Branch/jump resolution sequencer: drives the branch unit for one cycle, then redirects
// fetch and flushes younger stages on a taken branch. Optional BRC_BTFN_PRED_EN adds prediction.
module branch_ctrl #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned BU_OP_W      = 3,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned ILEN_BYTES   = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic [XLEN-1:0]    i_req_pc,
    input  logic [XLEN-1:0]    i_req_imm,
    input  logic [XLEN-1:0]    i_req_rs1,
    input  logic [XLEN-1:0]    i_req_rs2,
    input  logic [BU_OP_W-1:0] i_req_op,
    input  logic               i_req_jalr,
`ifdef BRC_BTFN_PRED_EN
    input  logic               i_req_pred_taken,
`endif
    output logic               o_bu_be,
    output logic [XLEN-1:0]    o_bu_a,
    output logic [XLEN-1:0]    o_bu_b,
    output logic [BU_OP_W-1:0] o_bu_op,
    input  logic               i_bu_take,
    output logic               o_redirect_valid,
    output logic [XLEN-1:0]    o_redirect_pc,
    input  logic               i_redirect_ready,
    output logic               o_flush,
    output logic               o_done,
    output logic [XLEN-1:0]    o_link_pc,
    output logic               o_misalign
);

    typedef enum logic [1:0] {StIdle, StResolve, StRedirect, StFlush} state_t;

    localparam logic [XLEN-1:0] ILEN_INC = XLEN'(ILEN_BYTES);
    localparam logic [3:0] CNT_INIT = (FLUSH_CYCLES == 0) ? 4'd0 : 4'(FLUSH_CYCLES - 1);

    state_t             state_q;
    logic [XLEN-1:0]    pc_q;
    logic [XLEN-1:0]    imm_q;
    logic [XLEN-1:0]    rs1_q;
    logic [XLEN-1:0]    rs2_q;
    logic [BU_OP_W-1:0] op_q;
    logic               jalr_q;
    logic [XLEN-1:0]    link_q;
    logic [XLEN-1:0]    redirect_pc_q;
    logic [3:0]         cnt_q;
    logic               pred;

    logic [XLEN-1:0]    base;
    logic [XLEN-1:0]    sum;
    logic [XLEN-1:0]    target;
    logic [XLEN-1:0]    fall_pc;
    logic [XLEN-1:0]    redir_target;
    logic               resolve;
    logic               res_misalign;
    logic               res_redir;
    logic               res_done;
    logic               handshake;

`ifdef BRC_BTFN_PRED_EN
    logic pred_q;
    assign pred = pred_q;
`else
    assign pred = 1'b0;
`endif

    always_comb begin
        base         = jalr_q ? rs1_q : pc_q;
        sum          = base + imm_q;
        target       = sum & ~{{(XLEN-1){1'b0}}, jalr_q};
        fall_pc      = pc_q + ILEN_INC;
        redir_target = i_bu_take ? target : fall_pc;

        // Pulses are suppressed while reset is asserted so an aborted request never retires.
        resolve      = (state_q == StResolve) && !i_rst;
        res_misalign = resolve && i_bu_take && (target[1:0] != 2'b00);
        res_redir    = resolve && !res_misalign && (i_bu_take != pred);
        res_done     = resolve && !res_redir;
        handshake    = (state_q == StRedirect) && i_redirect_ready && !i_rst;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= StIdle;
            pc_q          <= '0;
            imm_q         <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            op_q          <= '0;
            jalr_q        <= 1'b0;
            link_q        <= '0;
            redirect_pc_q <= '0;
            cnt_q         <= '0;
`ifdef BRC_BTFN_PRED_EN
            pred_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (i_req_valid) begin
                        pc_q    <= i_req_pc;
                        imm_q   <= i_req_imm;
                        rs1_q   <= i_req_rs1;
                        rs2_q   <= i_req_rs2;
                        op_q    <= i_req_op;
                        jalr_q  <= i_req_jalr;
                        link_q  <= i_req_pc + ILEN_INC;
`ifdef BRC_BTFN_PRED_EN
                        pred_q  <= i_req_pred_taken;
`endif
                        state_q <= StResolve;
                    end
                end
                StResolve: begin
                    if (res_redir) begin
                        redirect_pc_q <= redir_target;
                        state_q       <= StRedirect;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRedirect: begin
                    if (i_redirect_ready) begin
                        if (FLUSH_CYCLES == 0) begin
                            state_q <= StIdle;
                        end else begin
                            cnt_q   <= CNT_INIT;
                            state_q <= StFlush;
                        end
                    end
                end
                StFlush: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        o_req_ready      = (state_q == StIdle);
        o_bu_be          = (state_q == StResolve);
        o_bu_a           = rs1_q;
        o_bu_b           = rs2_q;
        o_bu_op          = op_q;
        o_redirect_valid = (state_q == StRedirect);
        o_redirect_pc    = redirect_pc_q;
        o_flush          = (state_q == StRedirect) || (state_q == StFlush);
        o_done           = res_done || handshake;
        o_link_pc        = link_q;
        o_misalign       = res_misalign;
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: acts as the branch unit, applies a directed table, a reset-abort
// sequence and randomized requests checked against a timeline model.
module tb_branch_ctrl;

    localparam int FC = 2;
    localparam logic [2:0] OP_BEQ = 3'd0, OP_BNE = 3'd1, OP_ALWAYS = 3'd2, OP_BLT = 3'd4,
                           OP_BGE = 3'd5, OP_BLTU = 3'd6, OP_BGEU = 3'd7;

    typedef struct {
        string       name;
        logic [31:0] pc, imm, rs1, rs2;
        logic [2:0]  op;
        logic        jalr, pred;
        int          delay;
        logic        exp_redir;
        logic [31:0] exp_rpc;
        logic        exp_mis;
    } req_t;

    logic clk = 1'b0;
    logic rst;
    logic req_valid, req_ready, req_jalr;
    logic [31:0] req_pc, req_imm, req_rs1, req_rs2;
    logic [2:0]  req_op;
    logic bu_be, bu_take;
    logic [31:0] bu_a, bu_b;
    logic [2:0]  bu_op;
    logic redirect_valid, redirect_ready, flush, done, misalign;
    logic [31:0] redirect_pc, link_pc;
`ifdef BRC_BTFN_PRED_EN
    logic pred_taken;
`endif

    int vectors = 0;
    int miscompares = 0;
    req_t tbl[$];
    req_t r;
    logic [2:0] ops [7] = '{OP_BEQ, OP_BNE, OP_ALWAYS, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};

    always #5 clk = ~clk;

    branch_ctrl #(.XLEN(32), .BU_OP_W(3), .FLUSH_CYCLES(FC), .ILEN_BYTES(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_pc(req_pc), .i_req_imm(req_imm), .i_req_rs1(req_rs1), .i_req_rs2(req_rs2),
        .i_req_op(req_op), .i_req_jalr(req_jalr),
`ifdef BRC_BTFN_PRED_EN
        .i_req_pred_taken(pred_taken),
`endif
        .o_bu_be(bu_be), .o_bu_a(bu_a), .o_bu_b(bu_b), .o_bu_op(bu_op), .i_bu_take(bu_take),
        .o_redirect_valid(redirect_valid), .o_redirect_pc(redirect_pc),
        .i_redirect_ready(redirect_ready), .o_flush(flush), .o_done(done),
        .o_link_pc(link_pc), .o_misalign(misalign)
    );

    function automatic logic bu_eval(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        case (op)
            OP_BEQ:    return a == b;
            OP_BNE:    return a != b;
            OP_BLT:    return $signed(a) < $signed(b);
            OP_BGE:    return $signed(a) >= $signed(b);
            OP_BLTU:   return a < b;
            OP_BGEU:   return a >= b;
            OP_ALWAYS: return 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

    assign bu_take = bu_eval(bu_op, bu_a, bu_b);

    function automatic req_t model(input req_t q);
        req_t o = q;
        logic take = bu_eval(q.op, q.rs1, q.rs2);
        logic [31:0] tgt = (q.jalr ? q.rs1 : q.pc) + q.imm;
        if (q.jalr) tgt = tgt & 32'hFFFF_FFFE;
        o.exp_mis   = take && (tgt % 4 != 0);
        o.exp_redir = !o.exp_mis && (take != q.pred);
        o.exp_rpc   = take ? tgt : q.pc + 32'd4;
        return o;
    endfunction

    function automatic req_t mk(input string n, input logic [31:0] pc, input logic [31:0] imm,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [2:0] op, input logic jalr, input logic pred,
                                input int delay, input logic redir, input logic [31:0] rpc,
                                input logic mis);
        req_t q;
        q.name = n; q.pc = pc; q.imm = imm; q.rs1 = rs1; q.rs2 = rs2; q.op = op;
        q.jalr = jalr; q.pred = pred; q.delay = delay;
        q.exp_redir = redir; q.exp_rpc = rpc; q.exp_mis = mis;
        return q;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_req(input req_t q);
        req_valid = 1'b1;
        req_pc = q.pc; req_imm = q.imm; req_rs1 = q.rs1; req_rs2 = q.rs2;
        req_op = q.op; req_jalr = q.jalr;
`ifdef BRC_BTFN_PRED_EN
        pred_taken = q.pred;
`endif
    endtask

    // Entered just after a rising edge with the DUT idle; returns the same way.
    task automatic run_req(input req_t q);
        int last = q.exp_redir ? 3 + q.delay + FC : 2;
        drive_req(q);
        redirect_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk({q.name, "/accept_ready"}, 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        for (int k = 1; k <= last; k++) begin
            logic in_redir = q.exp_redir && k >= 2 && k <= 2 + q.delay;
            logic [5:0] ec;
            req_valid = (k < last) ? 1'($urandom_range(0, 1)) : 1'b0;
            req_pc = $urandom; req_imm = $urandom; req_rs1 = $urandom; req_rs2 = $urandom;
            req_op = 3'($urandom); req_jalr = 1'($urandom);
            redirect_ready = in_redir ? (k == 2 + q.delay) : 1'($urandom_range(0, 1));
            ec = {k == last, k == 1, in_redir,
                  q.exp_redir && k >= 2 && k <= 2 + q.delay + FC,
                  (k == 1 && !q.exp_redir) || (q.exp_redir && k == 2 + q.delay),
                  k == 1 && q.exp_mis};
            @(negedge clk);
            chk($sformatf("%s/ctl{rdy,be,val,fl,done,mis}@%0d", q.name, k),
                64'({req_ready, bu_be, redirect_valid, flush, done, misalign}), 64'(ec));
            if (k == 1)
                chk({q.name, "/bu_ops"}, {bu_a, bu_b} ^ 64'(bu_op), {q.rs1, q.rs2} ^ 64'(q.op));
            if (in_redir)
                chk($sformatf("%s/redirect_pc@%0d", q.name, k), 64'(redirect_pc), 64'(q.exp_rpc));
            if (ec[1])
                chk({q.name, "/link_pc"}, 64'(link_pc), 64'(q.pc + 32'd4));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; redirect_ready = 1'b0;
        req_pc = '0; req_imm = '0; req_rs1 = '0; req_rs2 = '0; req_op = '0; req_jalr = 1'b0;
`ifdef BRC_BTFN_PRED_EN
        pred_taken = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset/ctl", 64'({req_ready, bu_be, redirect_valid, flush, done, misalign}),
            64'b100000);
        chk("reset/data", 64'(redirect_pc | link_pc | bu_a | bu_b), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        tbl.push_back(mk("beq_taken", 32'h100, 32'h20, 32'd5, 32'd5, OP_BEQ, 0, 0, 0,
                         1, 32'h120, 0));
        tbl.push_back(mk("bne_not", 32'h300, 32'h40, 32'd7, 32'd7, OP_BNE, 0, 0, 0,
                         0, 32'h304, 0));
        tbl.push_back(mk("jalr_mis", 32'h400, 32'h10, 32'h2003, 32'd0, OP_ALWAYS, 1, 0, 0,
                         0, 32'h2012, 1));
        tbl.push_back(mk("bltu_stall", 32'h500, 32'hFFFF_FFF0, 32'd1, 32'hFFFF_FFFF, OP_BLTU,
                         0, 0, 4, 1, 32'h4F0, 0));
        tbl.push_back(mk("jal", 32'h1000, 32'h800, 32'd0, 32'd0, OP_ALWAYS, 0, 0, 1,
                         1, 32'h1800, 0));
        tbl.push_back(mk("blt_signed", 32'h80, 32'h8, 32'hFFFF_FFFF, 32'd1, OP_BLT, 0, 0, 0,
                         1, 32'h88, 0));
        tbl.push_back(mk("bgeu_mis", 32'h10, 32'h6, 32'hFFFF_FFFF, 32'd0, OP_BGEU, 0, 0, 0,
                         0, 32'h16, 1));
        tbl.push_back(mk("jalr_bit0", 32'h700, 32'h0, 32'h3001, 32'd0, OP_ALWAYS, 1, 0, 2,
                         1, 32'h3000, 0));
        tbl.push_back(mk("wrap", 32'hFFFF_FFF0, 32'h20, 32'd9, 32'd9, OP_BEQ, 0, 0, 0,
                         1, 32'h10, 0));
`ifdef BRC_BTFN_PRED_EN
        tbl.push_back(mk("bge_mispred", 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd0, OP_BGE, 0, 1, 0,
                         1, 32'h204, 0));
        tbl.push_back(mk("beq_pred_ok", 32'h200, 32'h40, 32'd3, 32'd3, OP_BEQ, 0, 1, 0,
                         0, 32'h240, 0));
`else
        tbl.push_back(mk("bge_not", 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd0, OP_BGE, 0, 0, 0,
                         0, 32'h204, 0));
`endif
        foreach (tbl[i]) run_req(tbl[i]);

        // Reset while a redirect is pending must drop it without retiring.
        r = mk("rst_abort", 32'h600, 32'h10, 32'd1, 32'd1, OP_BEQ, 0, 0, 0, 1, 32'h610, 0);
        drive_req(r);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        redirect_ready = 1'b0;
        @(negedge clk);
        chk("rst_abort/pending", 64'({redirect_valid, flush, redirect_pc}), {2'b11, 32'h610});
        @(posedge clk); #1;
        rst = 1'b1; redirect_ready = 1'b1;
        @(negedge clk);
        chk("rst_abort/no_done_in_reset", 64'(done), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; redirect_ready = 1'b0;
        @(negedge clk);
        chk("rst_abort/after", 64'({req_ready, bu_be, redirect_valid, flush, done, misalign}),
            64'b100000);
        chk("rst_abort/regs", 64'(redirect_pc | link_pc), 64'd0);
        @(posedge clk); #1;
        run_req(mk("post_rst", 32'h900, 32'h8, 32'd2, 32'd2, OP_BEQ, 0, 0, 0, 1, 32'h908, 0));

        for (int i = 0; i < 40; i++) begin
            r.name  = $sformatf("rnd%0d", i);
            r.op    = ops[$urandom_range(0, 6)];
            r.pc    = $urandom & 32'hFFFF_FFFC;
            r.rs1   = $urandom;
            r.rs2   = ($urandom_range(0, 2) == 0) ? r.rs1 : $urandom;
            r.jalr  = (r.op == OP_ALWAYS) && ($urandom_range(0, 1) == 1);
            r.imm   = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            r.pred  = 1'b0;
`ifdef BRC_BTFN_PRED_EN
            r.pred  = 1'($urandom_range(0, 1));
`endif
            r.delay = $urandom_range(0, 3);
            run_req(model(r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
